// File: rtl/qout_frame_rx.sv
// Serial frame receiver: hunts for a sync word, then shifts in a payload and an
// even-parity bit, publishing the payload with a one-cycle Dvalid pulse.
module qout_frame_rx #(
    parameter logic [3:0] SYNC   = 4'b1011,
    parameter int         DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Din,
    input  logic              en,
    output logic [DATA_W-1:0] Dout,
    output logic              Dvalid,
    output logic              Perr,
    output logic              Busy,
    output logic [7:0]        FrameCnt
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state;
    // Only three history bits are kept; the fourth sync bit is Din itself.
    logic [2:0]        window;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] payload;

    assign Busy = (state != HUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            window   <= '0;
            cnt      <= '0;
            payload  <= '0;
            Dout     <= '0;
            Dvalid   <= 1'b0;
            Perr     <= 1'b0;
            FrameCnt <= '0;
        end else begin
            Dvalid <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if ({window, Din} == SYNC) begin
                            state  <= DATA;
                            cnt    <= '0;
                            window <= '0;
                        end else begin
                            window <= {window[1:0], Din};
                        end
                    end
                    DATA: begin
                        payload <= {payload[DATA_W-2:0], Din};
                        cnt     <= cnt + 1'b1;
                        if (cnt == CW'(DATA_W - 1))
                            state <= PARITY;
                    end
                    PARITY: begin
                        Dout     <= payload;
                        Perr     <= ^payload ^ Din;
                        Dvalid   <= 1'b1;
                        FrameCnt <= FrameCnt + 8'd1;
                        // Fresh window so no sync bit is shared across frames.
                        window   <= '0;
                        state    <= HUNT;
                    end
                    default: begin
                        state  <= HUNT;
                        window <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/qout_frame_rx.md
QOUT_FRAME_RX -- requirements
Module: qout_frame_rx

Interface
REQ-001 Parameter SYNC, default 4'b1011: sync pattern, MSB received first.
REQ-002 Parameter DATA_W, default 8: payload bits per frame.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: reset; synchronous, active-high.
REQ-005 Port Din, input, 1: serial bit stream from the upstream Moore FSM output.
REQ-006 Port en, input, 1: bit strobe; Din is sampled only on a posedge where en=1.
REQ-007 Port Dout, output, DATA_W: last received payload, MSB first; registered.
REQ-008 Port Dvalid, output, 1: one-cycle pulse marking a new Dout.
REQ-009 Port Perr, output, 1: even-parity error flag of the last frame; registered.
REQ-010 Port Busy, output, 1: high while the state is not HUNT.
REQ-011 Port FrameCnt, output, 8: count of completed frames; registered.

Function
REQ-012 The frame format SHALL be SYNC (4 bits), then DATA_W payload bits, then 1 parity bit.
REQ-013 The FSM SHALL have exactly three states: HUNT, DATA and PARITY.
REQ-014 Every state and register SHALL hold when en=0, except Dvalid.
REQ-015 HUNT: each sampled bit SHALL shift into a 4-bit window, and {window[2:0],Din}==SYNC SHALL move to DATA with the bit counter at 0.
REQ-016 DATA: each sampled bit SHALL shift into the payload register LSB-side, so the first payload bit ends as the MSB, and the counter SHALL increment.
REQ-017 DATA: the edge that samples payload bit DATA_W SHALL move to PARITY.
REQ-018 PARITY: the sampled bit on that edge SHALL cause the following, all on the same edge:
- Dout loaded with the payload;
- Perr set to the XOR of payload and parity bit (1 = odd total);
- Dvalid set;
- FrameCnt incremented;
- state returns to HUNT.
REQ-019 Dvalid SHALL be high for exactly the one cycle after the PARITY sampling edge, and low otherwise.
REQ-020 Dout and Perr SHALL hold their values until the next completed frame.
REQ-021 FrameCnt SHALL wrap from 255 to 0 without a flag.
REQ-022 The HUNT window SHALL be cleared on entry to HUNT, so sync bits are never shared between frames.
REQ-023 Busy SHALL be decoded from the state register, and SHALL be 1 in DATA and in PARITY.
REQ-024 The end-to-end latency SHALL be 1 cycle, from the parity-sampling edge to Dvalid and Dout being visible.

Reset
REQ-025 When rst=1 at posedge clk, the block SHALL enter HUNT with window=0, counter=0, payload=0, Dout=0, Dvalid=0, Perr=0, FrameCnt=0 and Busy=0.
REQ-026 rst SHALL take priority over en and Din.
REQ-027 A rst mid-frame SHALL discard the partial frame, and no Dvalid SHALL be produced for it.

Verification
REQ-028 Basic frame: rst, then with en=1 stream 1011, 10100101, 0 -> Dout=8'hA5, Dvalid=1 for one cycle, Perr=0, FrameCnt=1, Busy=0 after.
REQ-029 Parity error: same stream with parity bit 1 -> Dout=8'hA5, Perr=1, FrameCnt=1.
REQ-030 Strobe gaps: repeat REQ-028 with en=0 inserted between every bit and Din toggled while en=0 -> identical Dout, Perr and FrameCnt.
REQ-031 Late sync: stream 1,1,0,1,0,1,1 -> Busy rises only after the 7th bit; then payload 8'h3C with parity 0 -> Dout=8'h3C, Perr=0.
REQ-032 Reset mid-frame: sync plus 4 payload bits, then rst for 1 cycle -> Busy=0 and no Dvalid; then full frame 8'h3C -> Dout=8'h3C, FrameCnt=1.
REQ-033 Wrap: 256 back-to-back valid frames -> FrameCnt=0 and Dvalid pulsed 256 times.
